// File: rtl/p4_router_ingress_arbiter.sv
// p4_router_ingress_arbiter
//   Merges NUM_PORTS AXI-Stream-style ingress ports onto one converged bus.
//   Arbitration is weighted round-robin and frame-atomic. Each port gets up
//   to port_weight frames per turn, and a weight of 0 counts as 1. One IDLE
//   cycle separates frames. Frames longer than MTU are cut at MTU_BEATS: the
//   last forwarded beat is marked tlast/tuser, and the rest is drained in DROP.
//
// Ports
//   clk, sreset          : clock, synchronous active-high reset
//   in_t*                : per-port ingress streams, port p in slice p
//   port_weight          : frames per turn per port, sampled when credit loads
//   out_t*, out_tid      : registered converged stream plus its source port
//   oversize_trunc       : one-cycle pulse per truncated frame, aligned with the
//                          truncated tlast beat on out_*
//   arb_busy             : high while the FSM is not IDLE
module p4_router_ingress_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_BYTES   = 64,
  parameter int MTU_BYTES    = 1500,
  parameter int WEIGHT_WIDTH = 4,
  localparam int TID_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               sreset,
  input  logic [NUM_PORTS-1:0]               in_tvalid,
  output logic [NUM_PORTS-1:0]               in_tready,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0]  in_tdata,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]    in_tkeep,
  input  logic [NUM_PORTS-1:0]               in_tlast,
  input  logic [NUM_PORTS-1:0]               in_tuser,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0]  port_weight,
  output logic                               out_tvalid,
  input  logic                               out_tready,
  output logic [DATA_BYTES*8-1:0]            out_tdata,
  output logic [DATA_BYTES-1:0]              out_tkeep,
  output logic                               out_tlast,
  output logic                               out_tuser,
  output logic [TID_W-1:0]                   out_tid,
  output logic [NUM_PORTS-1:0]               oversize_trunc,
  output logic                               arb_busy
);

  localparam int DW        = DATA_BYTES * 8;
  localparam int MTU_BEATS = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
  localparam int BCNT_W    = $clog2(MTU_BEATS + 1);
  localparam logic [BCNT_W-1:0] MTU_LAST = BCNT_W'(MTU_BEATS);

  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;
  state_t state, state_nxt;

  logic [TID_W-1:0]        grant, last_grant;
  logic [WEIGHT_WIDTH-1:0] credit;
  logic [BCNT_W-1:0]       beat_cnt;

  // Granted port's stream.
  logic            g_valid, g_last, g_user;
  logic [DW-1:0]   g_data;
  logic [DATA_BYTES-1:0] g_keep;

  assign g_valid = in_tvalid[grant];
  assign g_last  = in_tlast[grant];
  assign g_user  = in_tuser[grant];
  assign g_data  = in_tdata[int'(grant)*DW +: DW];
  assign g_keep  = in_tkeep[int'(grant)*DATA_BYTES +: DATA_BYTES];

  // Round-robin search: first valid port strictly after last_grant, cyclic.
  logic             rr_found;
  logic [TID_W-1:0] rr_port;

  always_comb begin
    rr_found = 1'b0;
    rr_port  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!rr_found && in_tvalid[(int'(last_grant) + i) % NUM_PORTS]) begin
        rr_found = 1'b1;
        rr_port  = TID_W'((int'(last_grant) + i) % NUM_PORTS);
      end
    end
  end

  logic                    regrant, arb_go;
  logic [TID_W-1:0]        sel_port;
  logic [WEIGHT_WIDTH-1:0] sel_weight, eff_weight;

  // Regrant keeps the current turn alive. Otherwise a new turn starts and
  // credit is reloaded from the newly selected port's weight.
  assign regrant    = (credit != '0) && in_tvalid[last_grant];
  assign sel_port   = regrant ? last_grant : rr_port;
  assign sel_weight = port_weight[int'(rr_port)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign eff_weight = (sel_weight == '0) ? WEIGHT_WIDTH'(1) : sel_weight;
  assign arb_go     = (state == IDLE) && (|in_tvalid) && !sreset;

  // FSM next-state and handshake control.
  logic ready_g, take, fwd, trunc, frame_end, drop_end;

  always_comb begin
    state_nxt = state;
    ready_g   = 1'b0;
    take      = 1'b0;
    fwd       = 1'b0;
    trunc     = 1'b0;
    frame_end = 1'b0;
    drop_end  = 1'b0;
    case (state)
      IDLE: if (|in_tvalid) state_nxt = XFER;
      XFER: begin
        ready_g = !out_tvalid || out_tready;
        take    = ready_g && g_valid;
        if (take) begin
          fwd = 1'b1;
          if (g_last) begin
            frame_end = 1'b1;
            state_nxt = IDLE;
          end else if (BCNT_W'(beat_cnt + 1'b1) == MTU_LAST) begin
            // MTU reached without tlast: close the frame here, drain the rest.
            trunc     = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        ready_g = 1'b1;
        take    = g_valid;
        if (take && g_last) begin
          drop_end  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset wins combinationally, so no beat is taken on the reset edge.
    if (sreset) begin
      state_nxt = IDLE;
      ready_g   = 1'b0;
      take      = 1'b0;
      fwd       = 1'b0;
      trunc     = 1'b0;
      frame_end = 1'b0;
      drop_end  = 1'b0;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdy
    assign in_tready[p] = ready_g && (grant == TID_W'(p));
  end

  assign arb_busy = (state != IDLE) && !sreset;

  always_ff @(posedge clk) begin
    if (sreset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant, turn credit and per-frame beat count.
  always_ff @(posedge clk) begin
    if (sreset) begin
      grant      <= '0;
      last_grant <= TID_W'(NUM_PORTS - 1);
      credit     <= '0;
      beat_cnt   <= '0;
    end else begin
      if (arb_go) begin
        grant      <= sel_port;
        last_grant <= sel_port;
        beat_cnt   <= '0;
        if (!regrant) credit <= eff_weight;
      end
      if (fwd) beat_cnt <= beat_cnt + 1'b1;
      if (frame_end) credit <= (credit == '0) ? '0 : credit - 1'b1;
      // A truncated frame ends the turn, so the next frame goes to the next port.
      if (drop_end) credit <= '0;
    end
  end

  // Single output register stage; holds while stalled.
  always_ff @(posedge clk) begin
    if (sreset) begin
      out_tvalid     <= 1'b0;
      out_tdata      <= '0;
      out_tkeep      <= '0;
      out_tlast      <= 1'b0;
      out_tuser      <= 1'b0;
      out_tid        <= '0;
      oversize_trunc <= '0;
    end else begin
      oversize_trunc <= '0;
      if (fwd) begin
        out_tvalid              <= 1'b1;
        out_tdata               <= g_data;
        out_tkeep               <= g_keep;
        out_tlast               <= g_last || trunc;
        out_tuser               <= (g_last && g_user) || trunc;
        out_tid                 <= grant;
        oversize_trunc[grant]   <= trunc;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_p4_router_ingress_arbiter.sv
// Directed bench for p4_router_ingress_arbiter at its default parameters.
// A per-port frame source drives the ingress ports. Every forwarded beat is
// logged, and a per-port scoreboard checks beat content, ordering and
// non-interleaving.
module tb_p4_router_ingress_arbiter;
  localparam int NP = 4, DB = 64, DW = DB * 8, WW = 4;

  logic clk = 1'b0;
  logic sreset = 1'b1;
  logic [NP-1:0]    in_tvalid, in_tready, in_tlast, in_tuser;
  logic [NP*DW-1:0] in_tdata;
  logic [NP*DB-1:0] in_tkeep;
  logic [NP*WW-1:0] port_weight;
  logic             out_tvalid, out_tready, out_tlast, out_tuser;
  logic [DW-1:0]    out_tdata;
  logic [DB-1:0]    out_tkeep;
  logic [1:0]       out_tid;
  logic [NP-1:0]    oversize_trunc;
  logic             arb_busy;

  p4_router_ingress_arbiter dut (
    .clk(clk), .sreset(sreset),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tkeep(in_tkeep), .in_tlast(in_tlast), .in_tuser(in_tuser),
    .port_weight(port_weight),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tuser(out_tuser),
    .out_tid(out_tid), .oversize_trunc(oversize_trunc), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int frames_left[NP], flen[NP], bidx[NP], fnum[NP], trunc_cnt[NP];
  int sb_frame[NP], sb_beat[NP];
  bit user_cfg[NP];
  bit sb_en, bp, prev_open, prev_stall;
  int prev_tid;
  logic [580:0] prev_bus;
  int log_tid[$], log_last[$], log_user[$], log_beat[$], log_cyc[$];

  function automatic logic [DB-1:0] keep_of(bit last);
    logic [DB-1:0] k;
    k = '1;
    if (last) k = DB'(8'hFF);
    return k;
  endfunction

  task automatic drive_src();
    for (int p = 0; p < NP; p++) begin
      in_tvalid[p] = (frames_left[p] > 0);
      in_tlast[p]  = (bidx[p] == flen[p] - 1);
      in_tuser[p]  = in_tlast[p] && user_cfg[p];
      in_tdata[p*DW +: DW] = '0;
      in_tdata[p*DW +: 32] = {fnum[p][15:0], 8'(p), 8'(bidx[p])};
      in_tkeep[p*DB +: DB] = keep_of(in_tlast[p]);
    end
  endtask

  task automatic sb_check();
    int t;
    bit el, eu;
    logic [31:0] ed;
    t  = int'(out_tid);
    el = (sb_beat[t] == flen[t] - 1);
    eu = el && user_cfg[t];
    ed = {sb_frame[t][15:0], 8'(t), 8'(sb_beat[t])};
    checks++;
    if (out_tdata[31:0] !== ed || out_tlast !== el || out_tuser !== eu || out_tkeep !== keep_of(el)) begin
      failures++;
      $display("FAIL sb_beat tid=%0d got data=%h last=%b user=%b want data=%h last=%b user=%b",
               t, out_tdata[31:0], out_tlast, out_tuser, ed, el, eu);
    end
    checks++;
    if (prev_open && t != prev_tid) begin
      failures++;
      $display("FAIL interleave got tid=%0d want tid=%0d", t, prev_tid);
    end
    prev_open = !out_tlast;
    prev_tid  = t;
    if (el) begin sb_beat[t] = 0; sb_frame[t]++; end
    else sb_beat[t]++;
  endtask

  task automatic step();
    logic [NP-1:0] acc;
    @(negedge clk);
    acc = in_tvalid & in_tready;
    if (!sreset) begin
      for (int p = 0; p < NP; p++) trunc_cnt[p] += int'(oversize_trunc[p]);
      if (prev_stall) begin
        checks++;
        if ({out_tvalid, out_tlast, out_tuser, out_tid, out_tkeep, out_tdata} !== prev_bus) begin
          failures++;
          $display("FAIL stall_hold got tid=%0d data=%h want tid=%0d data=%h",
                   out_tid, out_tdata[31:0], prev_bus[DW+DB +: 2], prev_bus[31:0]);
        end
      end
      if (out_tvalid && out_tready) begin
        log_tid.push_back(int'(out_tid));
        log_last.push_back(int'(out_tlast));
        log_user.push_back(int'(out_tuser));
        log_beat.push_back(int'(out_tdata[7:0]));
        log_cyc.push_back(cyc);
        if (sb_en) sb_check();
      end
    end
    prev_stall = !sreset && out_tvalid && !out_tready;
    prev_bus   = {out_tvalid, out_tlast, out_tuser, out_tid, out_tkeep, out_tdata};
    @(posedge clk); #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        if (bidx[p] == flen[p] - 1) begin bidx[p] = 0; frames_left[p]--; fnum[p]++; end
        else bidx[p]++;
      end
    end
    drive_src();
    out_tready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  function automatic bit drained();
    bit d;
    d = !out_tvalid && !arb_busy;
    for (int p = 0; p < NP; p++) if (frames_left[p] != 0) d = 0;
    return d;
  endfunction

  task automatic run_drain(input int budget, input string name);
    int n;
    n = 0;
    while (!drained() && n < budget) begin step(); n++; end
    checks++;
    if (!drained()) begin
      failures++;
      $display("FAIL %s timeout got drained=0 want drained=1 after %0d cycles", name, budget);
    end
  endtask

  task automatic reset_env();
    sreset = 1'b1;
    bp = 0; sb_en = 1; prev_open = 0; prev_stall = 0; out_tready = 1'b1;
    for (int p = 0; p < NP; p++) begin
      frames_left[p] = 0; flen[p] = 1; bidx[p] = 0; fnum[p] = 0;
      trunc_cnt[p] = 0; sb_frame[p] = 0; sb_beat[p] = 0; user_cfg[p] = 0;
    end
    drive_src();
    log_tid.delete(); log_last.delete(); log_user.delete(); log_beat.delete(); log_cyc.delete();
    repeat (2) @(posedge clk);
    #1 sreset = 1'b0;
  endtask

  task automatic check_outputs_reset(input string name);
    checks++;
    if (out_tvalid !== 1'b0 || out_tlast !== 1'b0 || out_tuser !== 1'b0 || out_tid !== 2'd0 ||
        out_tdata !== '0 || out_tkeep !== '0 || oversize_trunc !== '0) begin
      failures++;
      $display("FAIL %s_regs got vld=%b last=%b user=%b tid=%0d trunc=%b want all zero",
               name, out_tvalid, out_tlast, out_tuser, out_tid, oversize_trunc);
    end
    checks++;
    if (in_tready !== '0 || arb_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_ctrl got in_tready=%b arb_busy=%b want 0000/0", name, in_tready, arb_busy);
    end
  endtask

  task automatic test_reset();
    sreset = 1'b1;
    port_weight = 16'h1111;
    for (int p = 0; p < NP; p++) begin frames_left[p] = 1; flen[p] = 2; bidx[p] = 0; fnum[p] = 0; user_cfg[p] = 0; end
    drive_src();
    out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_reset("reset");
    sreset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (arb_busy !== 1'b1 || in_tready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got busy=%b in_tready=%b want 1/0001", arb_busy, in_tready);
    end
  endtask

  task automatic check_intervals(input string name, input int want_tid[$]);
    int k;
    int last_c;
    k = 0; last_c = -1;
    for (int i = 0; i < log_tid.size(); i++) begin
      if (log_last[i] == 1) begin
        checks++;
        if (k >= want_tid.size() || log_tid[i] != want_tid[k]) begin
          failures++;
          $display("FAIL %s_order frame=%0d got tid=%0d want tid=%0d", name, k, log_tid[i],
                   (k < want_tid.size()) ? want_tid[k] : -1);
        end
        if (last_c >= 0) begin
          checks++;
          if (log_cyc[i] - last_c != 3) begin
            failures++;
            $display("FAIL %s_spacing frame=%0d got %0d cycles want 3", name, k, log_cyc[i] - last_c);
          end
        end
        last_c = log_cyc[i];
        k++;
      end
    end
    checks++;
    if (k != want_tid.size()) begin
      failures++;
      $display("FAIL %s_frames got %0d want %0d", name, k, want_tid.size());
    end
  endtask

  task automatic test_round_robin();
    reset_env();
    port_weight = 16'h1111;
    for (int p = 0; p < NP; p++) begin frames_left[p] = 2; flen[p] = 2; end
    drive_src();
    run_drain(200, "rr");
    check_intervals("rr", '{0, 1, 2, 3, 0, 1, 2, 3});
  endtask

  task automatic test_weights();
    int want[12] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
    int n;
    reset_env();
    port_weight = 16'h1113;
    for (int p = 0; p < NP; p++) begin frames_left[p] = 20; flen[p] = 1; end
    drive_src();
    n = 0;
    while (log_tid.size() < 12 && n < 200) begin step(); n++; end
    checks++;
    if (log_tid.size() < 12) begin
      failures++;
      $display("FAIL weights_timeout got %0d frames want 12", log_tid.size());
    end
    for (int i = 0; i < 12 && i < log_tid.size(); i++) begin
      checks++;
      if (log_tid[i] != want[i]) begin
        failures++;
        $display("FAIL weights_order frame=%0d got tid=%0d want tid=%0d", i, log_tid[i], want[i]);
      end
    end
  endtask

  task automatic test_oversize();
    int n2, lasts2, pos;
    reset_env();
    port_weight = 16'h1111;
    sb_en = 0;
    flen[2] = 30; frames_left[2] = 1;
    flen[3] = 2;  frames_left[3] = 1;
    drive_src();
    run_drain(300, "oversize");
    n2 = 0; lasts2 = 0; pos = -1;
    for (int i = 0; i < log_tid.size(); i++) begin
      if (log_tid[i] == 2) begin
        n2++;
        lasts2 += log_last[i];
        if (n2 == 24) pos = i;
      end
    end
    checks++;
    if (n2 != 24 || lasts2 != 1) begin
      failures++;
      $display("FAIL trunc_beats got beats=%0d lasts=%0d want beats=24 lasts=1", n2, lasts2);
    end
    checks++;
    if (pos < 0 || log_last[pos] != 1 || log_user[pos] != 1 || log_beat[pos] != 23) begin
      failures++;
      $display("FAIL trunc_tail got pos=%0d want tail beat 23 with tlast=1 tuser=1", pos);
    end
    checks++;
    if (trunc_cnt[2] != 1 || trunc_cnt[0] + trunc_cnt[1] + trunc_cnt[3] != 0) begin
      failures++;
      $display("FAIL trunc_pulse got %0d/%0d/%0d/%0d want 0/0/1/0",
               trunc_cnt[0], trunc_cnt[1], trunc_cnt[2], trunc_cnt[3]);
    end
    checks++;
    if (log_tid.size() != 26 || pos != 23 || log_tid[24] != 3 || log_tid[25] != 3) begin
      failures++;
      $display("FAIL trunc_next got beats=%0d pos=%0d want 26 beats, port 3 after the truncated frame",
               log_tid.size(), pos);
    end
    // Exactly MTU beats with tlast: legal frame, user flag passed through.
    reset_env();
    port_weight = 16'h1111;
    flen[0] = 24; frames_left[0] = 1; user_cfg[0] = 1;
    drive_src();
    run_drain(100, "mtu_exact");
    checks++;
    if (log_tid.size() != 24 || trunc_cnt[0] != 0) begin
      failures++;
      $display("FAIL mtu_exact got beats=%0d trunc=%0d want 24/0", log_tid.size(), trunc_cnt[0]);
    end
  endtask

  task automatic test_backpressure();
    reset_env();
    port_weight = 16'h3102;
    bp = 1;
    flen[0] = 1; flen[1] = 3; flen[2] = 5; flen[3] = 2;
    user_cfg[1] = 1; user_cfg[3] = 1;
    for (int p = 0; p < NP; p++) frames_left[p] = 4;
    drive_src();
    run_drain(2000, "bp");
    checks++;
    if (log_tid.size() != 44) begin
      failures++;
      $display("FAIL bp_count got %0d beats want 44", log_tid.size());
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    reset_env();
    port_weight = 16'h1111;
    flen[1] = 10; frames_left[1] = 1;
    drive_src();
    n = 0;
    while (bidx[1] != 4 && n < 100) begin step(); n++; end
    checks++;
    if (bidx[1] != 4) begin
      failures++;
      $display("FAIL midreset_reach got bidx=%0d want 4", bidx[1]);
    end
    sreset = 1'b1;
    #1;
    checks++;
    if (in_tready !== '0) begin
      failures++;
      $display("FAIL midreset_ready got %b want 0000", in_tready);
    end
    @(posedge clk); #1;
    check_outputs_reset("midreset");
    reset_env();
    port_weight = 16'h1111;
    flen[0] = 2; frames_left[0] = 1;
    flen[1] = 2; frames_left[1] = 1;
    drive_src();
    run_drain(100, "postreset");
    checks++;
    if (log_tid.size() != 4 || log_tid[0] != 0) begin
      failures++;
      $display("FAIL postreset_grant got beats=%0d first tid=%0d want 4 beats, first tid 0",
               log_tid.size(), (log_tid.size() > 0) ? log_tid[0] : -1);
    end
  endtask

  task automatic test_single_port_weight0();
    reset_env();
    port_weight = 16'h1101;
    flen[1] = 2; frames_left[1] = 3;
    drive_src();
    run_drain(100, "w0");
    check_intervals("w0", '{1, 1, 1});
  endtask

  initial begin
    out_tready = 1'b1;
    port_weight = 16'h1111;
    for (int p = 0; p < NP; p++) begin
      frames_left[p] = 0; flen[p] = 1; bidx[p] = 0; fnum[p] = 0; user_cfg[p] = 0;
    end
    drive_src();
    test_reset();
    test_round_robin();
    test_weights();
    test_oversize();
    test_backpressure();
    test_reset_midframe();
    test_single_port_weight0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p4_router_ingress_arbiter.md
P4_ROUTER_INGRESS_ARBITER -- requirements
Module: p4_router_ingress_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4: number of adapted ingress ports merged onto one converged bus.
REQ-002 The block SHALL have parameter DATA_BYTES, default 64: converged bus width in bytes.
REQ-003 The block SHALL have parameter MTU_BYTES, default 1500: largest legal frame.
REQ-004 The block SHALL have parameter WEIGHT_WIDTH, default 4: per-port weight width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 sreset  input  1  synchronous active-high reset.
REQ-008 in_tvalid  input  NUM_PORTS  per-port beat valid.
REQ-009 in_tready  output  NUM_PORTS  per-port beat accept.
REQ-010 in_tdata  input  NUM_PORTS*DATA_BYTES*8  per-port data, port p in slice p.
REQ-011 in_tkeep  input  NUM_PORTS*DATA_BYTES  per-port byte keep.
REQ-012 in_tlast  input  NUM_PORTS  per-port end of frame.
REQ-013 in_tuser  input  NUM_PORTS  per-port frame-error flag, sampled on the tlast beat.
REQ-014 port_weight  input  NUM_PORTS*WEIGHT_WIDTH  frames per turn; 0 treated as 1.
REQ-015 out_tvalid, out_tready, out_tdata, out_tkeep, out_tlast, out_tuser  output/input/output...  1/1/DATA_BYTES*8/DATA_BYTES/1/1  converged bus (out_tready is the only input).
REQ-016 out_tid  output  $clog2(NUM_PORTS) (min 1)  source port of the current beat.
REQ-017 oversize_trunc  output  NUM_PORTS  one-cycle pulse per truncated frame.
REQ-018 arb_busy  output  1  high while state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, XFER and DROP.
REQ-020 In IDLE with any in_tvalid high, the block SHALL select a granted port and enter XFER next cycle; with none valid, it SHALL stay in IDLE.
REQ-021 Selection: if credit>0 and in_tvalid[last_grant], the block SHALL regrant last_grant; otherwise it SHALL take the first valid port searching upward cyclically from last_grant+1 and load credit with its effective weight.
REQ-022 Arbitration SHALL be frame-atomic: the grant SHALL NOT change before the granted port's tlast beat is accepted.
REQ-023 in_tready[g] SHALL equal (state==XFER) && (!out_tvalid || out_tready); all other in_tready bits SHALL be 0, and all bits SHALL be 0 in IDLE and in reset.
REQ-024 Output SHALL be a single register stage: an accepted input beat SHALL appear on out_* the next cycle, and out_tid SHALL hold g.
REQ-025 out_* SHALL hold stable while out_tvalid && !out_tready.
REQ-026 On the accepted tlast beat, the block SHALL decrement credit (saturating at 0) and return to IDLE, giving a one-cycle arbitration bubble between frames.
REQ-027 A beat counter SHALL count accepted beats per frame; MTU_BEATS = ceil(MTU_BYTES/DATA_BYTES).
REQ-028 If beat MTU_BEATS is accepted without in_tlast, the block SHALL forward it with out_tlast=1 and out_tuser=1, pulse oversize_trunc[g], and enter DROP.
REQ-029 In DROP, in_tready[g] SHALL be 1, beats SHALL be discarded (no out_tvalid), and on in_tlast the block SHALL go to IDLE with credit forced to 0.
REQ-030 If in_tlast coincides with beat MTU_BEATS, the frame is legal: no truncation, no DROP.
REQ-031 out_tuser SHALL equal in_tuser on the forwarded tlast beat, ORed with truncation.
REQ-032 port_weight SHALL be sampled only when credit is loaded; changes mid-turn SHALL take effect on the next turn.

Reset
REQ-033 While sreset is high: state=IDLE, out_tvalid=0, out_tlast=0, out_tuser=0, out_tid=0, out_tdata=0, out_tkeep=0, in_tready=0, oversize_trunc=0, arb_busy=0, credit=0, beat counter=0.
REQ-034 After reset, last_grant SHALL be NUM_PORTS-1, so port 0 has first priority.
REQ-035 Reset mid-frame SHALL abandon the frame with no tail beat emitted; upstream owns the partial-frame remainder.

Verification
REQ-036 All 4 ports continuously valid with 2-beat frames and weights 1 -> grant order 0,1,2,3,0; 3 cycles per frame with out_tready=1.
REQ-037 Weights {3,1,1,1}, all ports busy -> port 0 sends 3 frames, then ports 1, 2 and 3 send 1 frame each, repeating.
REQ-038 MTU_BYTES=1500, DATA_BYTES=64 (24 beats), 30-beat frame on port 2 -> 24 beats out, beat 24 has tlast=1 and tuser=1, oversize_trunc[2] pulses once, 6 beats dropped, next grant is port 3.
REQ-039 Random out_tready backpressure at 50% -> out_* stable while stalled, no beat lost or duplicated, and frames not interleaved (scoreboard per out_tid).
REQ-040 sreset asserted on beat 5 of a 10-beat frame -> next cycle all outputs at reset values; first post-reset grant goes to port 0 when valid.
REQ-041 Only port 1 valid, weight 0 -> treated as 1, port 1 regranted every frame, with a 1-cycle IDLE bubble between frames.
